// File: rtl/cd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cd_ctrl_pkg
// Shared types and constants for the clock-divider limit controller.
//   cd_state_e        : controller FSM states
//   SETTLE_CNT_W      : width of the divided-clock period counter
//   TIMEOUT_CNT_W     : width of the optional waiting-state cycle counter
//   DEFAULT_LIMIT_DEF : default divide limit applied out of reset
// ---------------------------------------------------------------------------
package cd_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_EDGE = 2'd1,
        ST_SETTLE    = 2'd2,
        ST_ACK       = 2'd3
    } cd_state_e;

    localparam int SETTLE_CNT_W      = 4;
    localparam int TIMEOUT_CNT_W     = 21;
    localparam int DEFAULT_LIMIT_DEF = 2;

endpackage

// File: rtl/cd_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cd_rr_arbiter
// Round-robin arbiter. Priority starts at the index after the last winner
// (index 0 after reset). Masked requesters are not eligible.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_i       : request vector
//   mask_i      : requesters excluded from this arbitration
//   advance_i   : move the priority pointer past the current winner
//   grant_o     : one-hot winner (combinational)
//   valid_o     : at least one eligible requester
// ---------------------------------------------------------------------------
module cd_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] mask_i,
    input  logic            advance_i,
    output logic [NREQ-1:0] grant_o,
    output logic            valid_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   ptr_d;
    logic [PW-1:0]   win_idx;
    logic [NREQ-1:0] elig;

    assign elig = req_i & ~mask_i;

    // Scan from the pointer upward with wrap; first eligible index wins.
    always_comb begin
        logic          found;
        logic [PW-1:0] cand;
        found   = 1'b0;
        cand    = '0;
        grant_o = '0;
        win_idx = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = PW'((int'(ptr_q) + off) % NREQ);
            if (!found && elig[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                win_idx       = cand;
            end
        end
        valid_o = found;
    end

    assign ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance_i && valid_o) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cd_limit_ctrl.sv
// ---------------------------------------------------------------------------
// cd_limit_ctrl
// Owns the `limit` input of the clock-divider counter and shares it between
// NREQ requesters (level req/ack handshake, round-robin arbitration). A new
// limit is applied only on a rising edge of the divided clock, when the
// counter is at 0, and the request is acknowledged after SETTLE_PERIODS
// full periods at the new ratio.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   req        : per-requester request level, held until ack
//   req_limit  : requested limits, slice i belongs to requester i
//   ack        : one-cycle acknowledge to the serviced requester
//   err        : with ack, 1 = rejected (zero limit) or aborted
//   grant      : one-hot, acceptance through the ack cycle
//   busy       : controller not idle
//   cd_clkout  : divided clock fed back from the counter
//   limit_out  : divide limit driving the counter
// Optional feature: define CD_LIMIT_CTRL_TIMEOUT_EN to bound each waiting
// state to TIMEOUT_CYCLES clk cycles (ack with err=1 on expiry).
// ---------------------------------------------------------------------------
module cd_limit_ctrl
    import cd_ctrl_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int WIDTH          = 32,
    parameter int DEFAULT_LIMIT  = DEFAULT_LIMIT_DEF,
    parameter int SETTLE_PERIODS = 2,
    parameter int TIMEOUT_CYCLES = 2 ** 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_limit,
    output logic [NREQ-1:0]       ack,
    output logic                  err,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    input  logic                  cd_clkout,
    output logic [WIDTH-1:0]      limit_out
);

    if (NREQ < 2 || NREQ > 8 || DEFAULT_LIMIT == 0 || SETTLE_PERIODS < 1 ||
        SETTLE_PERIODS > 15 || TIMEOUT_CYCLES < 1 ||
        TIMEOUT_CYCLES > (2 ** TIMEOUT_CNT_W)) begin : g_bad_params
        $error("cd_limit_ctrl: parameter out of range");
    end

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_PERIODS - 1);

    cd_state_e               state_q;
    logic [NREQ-1:0]         grant_q;
    logic [NREQ-1:0]         ack_q;
    logic                    err_q;
    logic [NREQ-1:0]         mask_q;
    logic [WIDTH-1:0]        pending_q;
    logic [WIDTH-1:0]        limit_q;
    logic [SETTLE_CNT_W-1:0] settle_cnt_q;
    logic                    clkout_q;

    logic [NREQ-1:0]  arb_grant;
    logic             arb_valid;
    logic [WIDTH-1:0] win_limit;
    logic [WIDTH-1:0] limit_arr [NREQ];
    logic             rise;
    logic             win_req;

`ifdef CD_LIMIT_CTRL_TIMEOUT_EN
    localparam logic [TIMEOUT_CNT_W-1:0] TO_LAST = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_CNT_W-1:0] to_cnt_q;
    logic [WIDTH-1:0]         prev_limit_q;
    logic                     to_expired;
    assign to_expired = (to_cnt_q == TO_LAST);
`endif

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign limit_arr[gi] = req_limit[gi*WIDTH +: WIDTH];
    end

    cd_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req),
        .mask_i    (mask_q),
        .advance_i (state_q == ST_IDLE),
        .grant_o   (arb_grant),
        .valid_o   (arb_valid)
    );

    always_comb begin
        win_limit = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                win_limit = win_limit | limit_arr[i];
            end
        end
    end

    assign rise    = cd_clkout & ~clkout_q;
    assign win_req = |(req & grant_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            ack_q        <= '0;
            err_q        <= 1'b0;
            mask_q       <= '0;
            pending_q    <= '0;
            limit_q      <= WIDTH'(DEFAULT_LIMIT);
            settle_cnt_q <= '0;
            clkout_q     <= 1'b0;
`ifdef CD_LIMIT_CTRL_TIMEOUT_EN
            to_cnt_q     <= '0;
            prev_limit_q <= WIDTH'(DEFAULT_LIMIT);
`endif
        end else begin
            clkout_q <= cd_clkout;
            ack_q    <= '0;
            err_q    <= 1'b0;
            // Mask lives for exactly the first IDLE cycle after ACK.
            mask_q   <= '0;
`ifdef CD_LIMIT_CTRL_TIMEOUT_EN
            to_cnt_q <= to_cnt_q + 1'b1;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_q   <= arb_grant;
                        pending_q <= win_limit;
                        if (win_limit == '0) begin
                            ack_q   <= arb_grant;
                            err_q   <= 1'b1;
                            state_q <= ST_ACK;
                        end else if (win_limit == limit_q) begin
                            // Nothing to change; do not disturb the divider.
                            ack_q   <= arb_grant;
                            state_q <= ST_ACK;
                        end else begin
                            state_q <= ST_WAIT_EDGE;
`ifdef CD_LIMIT_CTRL_TIMEOUT_EN
                            to_cnt_q <= '0;
`endif
                        end
                    end
                end
                ST_WAIT_EDGE: begin
                    // The rise has priority over a dropped request: the
                    // counter is at 0 now, so the change is clean.
                    if (rise) begin
                        limit_q      <= pending_q;
                        settle_cnt_q <= '0;
                        state_q      <= ST_SETTLE;
`ifdef CD_LIMIT_CTRL_TIMEOUT_EN
                        prev_limit_q <= limit_q;
                        to_cnt_q     <= '0;
`endif
                    end else if (!win_req) begin
                        ack_q   <= grant_q;
                        err_q   <= 1'b1;
                        state_q <= ST_ACK;
                    end
`ifdef CD_LIMIT_CTRL_TIMEOUT_EN
                    else if (to_expired) begin
                        ack_q   <= grant_q;
                        err_q   <= 1'b1;
                        state_q <= ST_ACK;
                    end
`endif
                end
                ST_SETTLE: begin
                    if (rise) begin
                        if (settle_cnt_q == SETTLE_LAST) begin
                            ack_q   <= grant_q;
                            state_q <= ST_ACK;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + 1'b1;
                        end
                    end
`ifdef CD_LIMIT_CTRL_TIMEOUT_EN
                    else if (to_expired) begin
                        limit_q <= prev_limit_q;
                        ack_q   <= grant_q;
                        err_q   <= 1'b1;
                        state_q <= ST_ACK;
                    end
`endif
                end
                ST_ACK: begin
                    grant_q <= '0;
                    mask_q  <= grant_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign grant     = grant_q;
    assign busy      = (state_q != ST_IDLE);
    assign limit_out = limit_q;

endmodule

// File: tb/tb_cd_limit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cd_limit_ctrl
// Directed bench with a behavioural divider counter attached to limit_out.
// Expected acks (requester, err, limit_out) are queued when a request is
// driven and compared when the DUT pulses ack.
// ---------------------------------------------------------------------------
module tb_cd_limit_ctrl;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] req_limit = '0;
    logic [NREQ-1:0]       ack;
    logic                  err;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  cd_clkout;
    logic [WIDTH-1:0]      limit_out;

    always #5 clk = ~clk;

    cd_limit_ctrl #(
        .NREQ           (NREQ),
        .WIDTH          (WIDTH),
        .DEFAULT_LIMIT  (2),
        .SETTLE_PERIODS (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_limit (req_limit),
        .ack       (ack),
        .err       (err),
        .grant     (grant),
        .busy      (busy),
        .cd_clkout (cd_clkout),
        .limit_out (limit_out)
    );

    // Divider counter model: toggles its output every limit_out clk cycles.
    logic [31:0] div_cnt;
    logic        div_clk;
    logic        div_en = 1'b1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            div_clk <= 1'b0;
        end else if (div_en) begin
            if (div_cnt >= limit_out - 1) begin
                div_cnt <= '0;
                div_clk <= ~div_clk;
            end else begin
                div_cnt <= div_cnt + 1;
            end
        end
    end
    assign cd_clkout = div_clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] cur_limit = 32'd2;

    typedef struct {
        int          idx;
        logic        e;
        logic [31:0] lim;
    } sb_t;
    sb_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int idx, input logic e, input logic [31:0] lim);
        sb_t t;
        t.idx = idx;
        t.e   = e;
        t.lim = lim;
        sb.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic v, input logic [31:0] lim);
        req[idx] = v;
        req_limit[idx*WIDTH +: WIDTH] = lim;
    endtask

    task automatic wait_ack(output int at_cyc);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (ack == '0 && k < 500);
        chk("ack_seen", {31'b0, ack != '0}, 32'd1);
        at_cyc = cyc;
    endtask

    // Scoreboard consumer: one pop per ack cycle.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ack != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {28'b0, ack}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("ack req=%0d err=%0b limit_out=%0d (exp req=%0d err=%0b limit=%0d)",
                             $clog2(ack), err, limit_out, e.idx, e.e, e.lim);
                    chk("ack_idx", {28'b0, ack}, 32'd1 << e.idx);
                    chk("ack_err", {31'b0, err}, {31'b0, e.e});
                    chk("ack_limit", limit_out, e.lim);
                end
            end
        end
    end

    // Normal limit change by one requester, optionally dropping req in SETTLE.
    task automatic single(input int idx, input logic [31:0] lim, input bit drop_settle);
        int t_apply, t_ack;
        logic s1, s2;
        logic [31:0] old;
        bit found;
        tick();
        old = limit_out;
        set_req(idx, 1'b1, lim);
        push(idx, 1'b0, lim);
        @(negedge clk); s2 = cd_clkout;
        @(negedge clk); s1 = cd_clkout;
        chk("single_grant", {28'b0, grant}, 32'd1 << idx);
        chk("single_busy", {31'b0, busy}, 32'd1);
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (limit_out !== old) found = 1;
            else begin s2 = s1; s1 = cd_clkout; end
        end
        t_apply = cyc;
        chk("limit_applied", limit_out, lim);
        chk("rise_before_apply", {30'b0, s2, s1}, 32'd1);
        if (drop_settle) begin tick(); set_req(idx, 1'b0, lim); end
        wait_ack(t_ack);
        chk("settle_cycles", t_ack - t_apply, 4 * lim);
        if (!drop_settle) begin tick(); set_req(idx, 1'b0, lim); end
        cur_limit = lim;
    endtask

    // Two simultaneous requesters; `a` is expected to win first.
    task automatic pair(input int a, input logic [31:0] la, input int b, input logic [31:0] lb);
        int t;
        tick();
        set_req(a, 1'b1, la);
        set_req(b, 1'b1, lb);
        push(a, 1'b0, la);
        push(b, 1'b0, lb);
        @(negedge clk);
        @(negedge clk);
        chk("pair_first_grant", {28'b0, grant}, 32'd1 << a);
        wait_ack(t);
        tick();
        set_req(a, 1'b0, la);
        @(negedge clk);
        @(negedge clk);
        chk("pair_second_grant", {28'b0, grant}, 32'd1 << b);
        wait_ack(t);
        tick();
        set_req(b, 1'b0, lb);
        cur_limit = lb;
    endtask

    // Zero or same-limit request: ack at N+1, busy low at N+2.
    task automatic quick(input int idx, input logic [31:0] lim, input logic e);
        tick();
        set_req(idx, 1'b1, lim);
        push(idx, e, cur_limit);
        @(negedge clk);
        @(negedge clk);
        chk("quick_ack", {28'b0, ack}, 32'd1 << idx);
        chk("quick_err", {31'b0, err}, {31'b0, e});
        tick();
        set_req(idx, 1'b0, lim);
        @(negedge clk);
        chk("quick_busy_low", {31'b0, busy}, 32'd0);
        chk("quick_limit", limit_out, cur_limit);
    endtask

    // Divider frozen so no rise arrives; requester gives up in WAIT_EDGE.
    task automatic wait_drop(input int idx, input logic [31:0] lim);
        int t;
        tick();
        div_en = 1'b0;
        tick();
        tick();
        set_req(idx, 1'b1, lim);
        push(idx, 1'b1, cur_limit);
        @(negedge clk);
        @(negedge clk);
        chk("drop_grant", {28'b0, grant}, 32'd1 << idx);
        tick();
        tick();
        chk("drop_still_waiting", {31'b0, busy}, 32'd1);
        set_req(idx, 1'b0, lim);
        wait_ack(t);
        chk("drop_limit_kept", limit_out, cur_limit);
        tick();
        div_en = 1'b1;
    endtask

    task automatic rise_gap();
        int t0;
        logic p;
        int found;
        t0 = 0;
        found = 0;
        @(negedge clk); p = cd_clkout;
        for (int k = 0; k < 50 && found < 2; k++) begin
            @(negedge clk);
            if (cd_clkout && !p) begin
                found++;
                if (found == 1) t0 = cyc;
            end
            p = cd_clkout;
        end
        chk("default_period", cyc - t0, 32'd4);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        @(negedge clk);
        chk("rst_limit", limit_out, 32'd2);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_grant", {28'b0, grant}, 32'd0);
        chk("rst_ack", {28'b0, ack}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        tick();
        rst_n = 1'b1;
        rise_gap();

        pair(0, 32'd3, 2, 32'd4);   // pointer 0: 0 wins, then 2
        single(1, 32'd5, 1'b0);     // 20 clk from apply to ack
        pair(2, 32'd6, 0, 32'd3);   // pointer now 2: 2 wins, then 0
        quick(3, 32'd0, 1'b1);      // zero limit rejected
        quick(1, 32'd3, 1'b0);      // same limit
        wait_drop(0, 32'd7);
        single(2, 32'd4, 1'b1);     // drop in SETTLE is ignored

        // Reset while settling at a new limit.
        tick();
        set_req(1, 1'b1, 32'd9);
        push(1, 1'b0, 32'd9);
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (limit_out == 32'd9) found = 1;
        end
        chk("reset_pre_applied", limit_out, 32'd9);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midreset_limit", limit_out, 32'd2);
        chk("midreset_busy", {31'b0, busy}, 32'd0);
        chk("midreset_grant", {28'b0, grant}, 32'd0);
        sb.delete();
        set_req(1, 1'b0, 32'd0);
        tick();
        rst_n = 1'b1;
        cur_limit = 32'd2;

        pair(1, 32'd3, 3, 32'd5);   // pointer back at 0 after reset

        repeat (5) tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cd_limit_ctrl.md
# cd_limit_ctrl

Controller that owns the `limit` input of the clock-divider counter and shares it between several requesters. Requesters ask for a new divide limit through a level req/ack handshake, and a round-robin arbiter selects one request at a time. The new limit is applied only on a rising edge of the divider output, while the counter is at 0, so no runt or stretched half-period is produced. The request is acknowledged after the divided clock has run a fixed number of periods at the new ratio. The block sits between the system's clock-management requesters and the clock-divider counter.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8.
- WIDTH, 32: limit width; equal to the counter width.
- DEFAULT_LIMIT, 2: value of `limit_out` after reset; must be nonzero.
- SETTLE_PERIODS, 2: full divided-clock periods to wait after a limit change before ack; 1..15.
- TIMEOUT_CYCLES, 2^20: clk cycles allowed per waiting state; used only when the timeout feature is compiled in.

Ports:
- clk  in  1: system clock; the same clock drives the divider counter.
- rst_n  in  1: reset, asynchronous, active-low.
- req  in  NREQ: per-requester request, level; held until ack.
- req_limit  in  NREQ*WIDTH: requested limit; slice i belongs to requester i; held stable while req[i]=1.
- ack  out  NREQ: one-cycle pulse to the serviced requester.
- err  out  1: valid with ack; 1 means the request was rejected or aborted.
- grant  out  NREQ: one-hot, registered; high from acceptance through the ack cycle.
- busy  out  1: FSM not in IDLE.
- cd_clkout  in  1: divided clock fed back from the counter.
- limit_out  out  WIDTH: registered; drives the counter `limit` input.

## Operation
- FSM states are IDLE, WAIT_EDGE, SETTLE, ACK.
- Edge detect: `clkout_q` is a registered copy of cd_clkout; a rising edge (rise) is cd_clkout=1 and clkout_q=0.
- IDLE
  - If no req is eligible, stay in IDLE.
  - Otherwise a round-robin arbiter picks the winner. Priority starts at the index after the last winner; after reset the start index is 0.
  - The winner's req_limit is latched into `pending`, and `grant` is set to the winner.
  - If pending=0: go to ACK with err=1; limit_out is unchanged.
  - If pending=limit_out: go to ACK with err=0; no disruption to the divider.
  - Otherwise: go to WAIT_EDGE.
- WAIT_EDGE
  - On rise: limit_out <= pending, clear the period counter, go to SETTLE. The counter is 0 in this cycle.
  - If req[winner] drops before rise: abort, go to ACK with err=1; limit_out is unchanged.
- SETTLE
  - Count rises. When the count reaches SETTLE_PERIODS, go to ACK with err=0.
  - Dropping req in this state is ignored; the limit is already committed.
- ACK
  - ack[winner]=1 for exactly one cycle; grant clears on exit; return to IDLE.
  - The last winner is masked from arbitration in the first IDLE cycle after ACK, so a req still high from the ack cycle is not re-accepted.
- Requests arriving while busy are held off; there is no queue beyond the req levels.
- Multiple simultaneous req: exactly one wins per arbitration; the others wait their round-robin turn.

## Timing
- Reset values: limit_out=DEFAULT_LIMIT, ack=0, err=0, grant=0, busy=0, state=IDLE, rr pointer=0, clkout_q=0, pending=0.
- Outputs are Moore-decoded from registers; there are no combinational paths from inputs to outputs.
- req sampled high in IDLE at cycle N: grant and busy are high at N+1.
- Same-limit or zero-limit request: ack and err at N+1; busy low at N+2.
- Normal change: limit_out updates in the cycle after the first rise detected in WAIT_EDGE. ack follows one cycle after the SETTLE_PERIODS-th rise at the new ratio.
- Rise coincident with req dropping in WAIT_EDGE: the rise wins; the limit is applied and the change completes.
- Reset mid-operation: all state returns to reset values immediately and limit_out returns to DEFAULT_LIMIT. Pending requesters must re-handshake.
- Width rule: comparisons are unsigned WIDTH-bit. The SETTLE counter is 4 bits.

## Configuration
- Macro: `CD_LIMIT_CTRL_TIMEOUT_EN`.
- With the macro defined:
  - A 21-bit cycle counter restarts on each entry to WAIT_EDGE or SETTLE.
  - Timeout in WAIT_EDGE: go to ACK with err=1; limit_out is unchanged.
  - Timeout in SETTLE: restore the previous limit_out, then go to ACK with err=1.
- Without the macro: no timeout counter; the waiting states wait indefinitely.

## Structure
- Package `cd_ctrl_pkg` holds:
  - the FSM state enum;
  - the SETTLE counter width constant (4);
  - the timeout counter width constant (21);
  - the DEFAULT_LIMIT default.
- Sub-module `cd_rr_arbiter`, parameterised by NREQ:
  - inputs: req vector, mask, advance strobe;
  - outputs: one-hot grant and valid.

## Test plan
- Reset, then idle: limit_out=2, busy=0; with the counter attached, cd_clkout toggles every 2 clk.
- Requester 1 asks for 5: grant=0010. limit_out becomes 5 in the cycle after the next rise of cd_clkout. ack[1] and err=0 follow after 2 periods of 10 clk.
- req[0] and req[2] asserted together, each asking for a new limit: 0 is serviced first, then 2. Repeat with both high again: 2 is serviced before 0.
- Request for limit 0: ack at N+1 with err=1; limit_out unchanged. Request equal to the current limit: ack at N+1 with err=0.
- Requester drops req while in WAIT_EDGE: ack with err=1 and limit_out unchanged. Drop while in SETTLE: change completes with err=0.
- rst_n pulsed low during SETTLE: limit_out=2 immediately. With the timeout macro and cd_clkout forced low: ack with err=1 after 2^20 cycles.
